// File: rtl/sum_loop_if.sv
// Handshake and datapath-control bundle for sum_loop_controller.
// master: the controller. It receives the command inputs (start, pause) and the
//         datapath comparator (ALtN), and drives the load/select lines and status.
// slave:  the command logic and datapath on the other side.
// Signals:
//   start, pause                  command inputs
//   ALtN                          datapath comparator A < N
//   ASrcMuxSel, ALoad             A register select / load
//   SumSrcMuxSel, SumLoad         Sum register select / load
//   OutLoad                       output register load
//   busy, done, timeout           status
//   iter_count                    increments performed in current/last job
interface sum_loop_if #(
  parameter int unsigned ITER_W = 8
);
  logic              start;
  logic              pause;
  logic              ALtN;
  logic              ASrcMuxSel;
  logic              ALoad;
  logic              SumSrcMuxSel;
  logic              SumLoad;
  logic              OutLoad;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [ITER_W-1:0] iter_count;

  modport master (
    input  start, pause, ALtN,
    output ASrcMuxSel, ALoad, SumSrcMuxSel, SumLoad, OutLoad,
    output busy, done, timeout, iter_count
  );

  modport slave (
    output start, pause, ALtN,
    input  ASrcMuxSel, ALoad, SumSrcMuxSel, SumLoad, OutLoad,
    input  busy, done, timeout, iter_count
  );
endinterface

// File: rtl/sum_loop_controller.sv
// Moore FSM sequencing the counter/accumulator datapath that computes
// Sum = 0 + 1 + ... + (N-1). One job runs per start pulse accepted in IDLE or FAULT.
// Owns every datapath load/select line, adds a start/busy/done handshake, a pause
// hold and an iteration watchdog that parks the FSM in FAULT after MAX_ITER increments.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; returns to IDLE with iter_count cleared
//   bus    sum_loop_if.master (command inputs, comparator, loads/selects, status)
// Parameters:
//   ITER_W    width of iter_count
//   MAX_ITER  increment count that trips the watchdog (1 .. 2^ITER_W-1)
module sum_loop_controller #(
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic           clk,
  input  logic           reset,
  sum_loop_if.master     bus
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StCmp,
    StAcc,
    StInc,
    StOut,
    StDone,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] iter_inc;

  logic a_sel, a_load, sum_sel, sum_load, out_load;
  logic busy, done, timeout;

  assign iter_inc = iter_q + ITER_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next state plus state-decoded outputs. While paused in an active state the
  // state and counter hold and every load enable is forced low; selects still
  // follow the held state so the datapath mux inputs stay stable.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    a_sel    = 1'b0;
    a_load   = 1'b0;
    sum_sel  = 1'b0;
    sum_load = 1'b0;
    out_load = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StInit;
      end

      StInit: begin
        busy     = 1'b1;
        a_load   = ~bus.pause;
        sum_load = ~bus.pause;
        if (!bus.pause) begin
          iter_d  = '0;
          state_d = StCmp;
        end
      end

      StCmp: begin
        busy = 1'b1;
        if (!bus.pause) state_d = bus.ALtN ? StAcc : StOut;
      end

      StAcc: begin
        busy     = 1'b1;
        sum_sel  = 1'b1;
        sum_load = ~bus.pause;
        if (!bus.pause) state_d = StInc;
      end

      StInc: begin
        busy   = 1'b1;
        a_sel  = 1'b1;
        a_load = ~bus.pause;
        if (!bus.pause) begin
          iter_d  = iter_inc;
          // Watchdog: this increment is the MAX_ITER-th of the job.
          state_d = (iter_inc == ITER_W'(MAX_ITER)) ? StFault : StCmp;
        end
      end

      StOut: begin
        busy     = 1'b1;
        out_load = ~bus.pause;
        if (!bus.pause) state_d = StDone;
      end

      StDone: begin
        // start is deliberately not sampled here; a new job needs IDLE.
        done    = 1'b1;
        state_d = StIdle;
      end

      StFault: begin
        timeout = 1'b1;
        if (bus.start) state_d = StInit;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.ASrcMuxSel   = a_sel;
  assign bus.ALoad        = a_load;
  assign bus.SumSrcMuxSel = sum_sel;
  assign bus.SumLoad      = sum_load;
  assign bus.OutLoad      = out_load;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.timeout      = timeout;
  assign bus.iter_count   = iter_q;

endmodule
